alu_mc: RTL and testbench
=========================

ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 SHALL have parameter N, default 32, meaning operand/result width in bits (N >= 4).
REQ-002 SHALL have port clk  input  1  rising-edge clock, the only clock.
REQ-003 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-004 SHALL have port in_valid  input  1  request present.
REQ-005 SHALL have port in_ready  output  1  block can accept a request.
REQ-006 SHALL have port opcode  input  3  operation select.
REQ-007 SHALL have port operandA  input  N  first operand.
REQ-008 SHALL have port operandB  input  N  second operand.
REQ-009 SHALL have port out_valid  output  1  result and flags valid.
REQ-010 SHALL have port out_ready  input  1  consumer takes result.
REQ-011 SHALL have port result  output  N  operation result.
REQ-012 SHALL have ports C_Flag, O_Flag, N_Flag, Z_Flag  output  1 each  carry, overflow, negative, zero.

Function
REQ-013 SHALL implement FSM states IDLE, BUSY, DONE; in_ready = 1 only in IDLE.
REQ-014 SHALL accept a request on a clk edge where state = IDLE and in_valid = 1, registering opcode and operands.
REQ-015 SHALL decode opcode: 000 add, 001 sub (A-B), 010 mul, 011 and, 100 or, 101 unsigned div (A/B), 110 xor, 111 logical shift left A by B[log2(N)-1:0].
REQ-016 SHALL, for single-cycle ops (all except 010/101), go IDLE -> DONE at the accepting edge; out_valid high in the next cycle (latency 1).
REQ-017 SHALL, for mul/div, go IDLE -> BUSY at the accepting edge, iterate exactly N cycles using a counter, then BUSY -> DONE; out_valid first high N+1 cycles after acceptance.
REQ-018 SHALL implement mul as iterative unsigned shift-add; result = low N bits of 2N-bit product.
REQ-019 SHALL implement div as iterative restoring unsigned division; result = quotient.
REQ-020 SHALL, for div with operandB = 0, still take N+1 cycles and return result all ones, O_Flag = 1.
REQ-021 SHALL set C_Flag: add = carry out of bit N-1; sub = 1 when A >= B unsigned (no borrow); 0 for all other ops.
REQ-022 SHALL set O_Flag: add/sub = two's-complement signed overflow; mul = 1 if upper N product bits nonzero; div = REQ-020; 0 otherwise.
REQ-023 SHALL set N_Flag = result[N-1] and Z_Flag = (result == 0) for every op.
REQ-024 SHALL hold result and all flags stable in DONE while out_ready = 0.
REQ-025 SHALL go DONE -> IDLE on an edge where out_valid = 1 and out_ready = 1; out_valid low in the following cycle.
REQ-026 SHALL not accept a new request in the same cycle as result handoff (minimum 1 idle cycle between transactions).
REQ-027 SHALL ignore opcode/operand changes after acceptance; in_valid is not sampled in BUSY or DONE.

Reset
REQ-028 SHALL, when rst = 1 at a clk edge, enter IDLE from any state, including mid-BUSY, discarding the operation.
REQ-029 SHALL drive after reset: in_ready = 1, out_valid = 0, result = 0, all flags = 0, iteration counter = 0.
REQ-030 SHALL give rst priority over any simultaneous request or handoff.

Verification
REQ-031 SHALL pass: sub A=32, B=32 -> 1 cycle later result 0, Z=1, C=1, N=0, O=0.
REQ-032 SHALL pass: sub A=32, B=64 -> result 0xFFFFFFE0, N=1, C=0, Z=0.
REQ-033 SHALL pass: add A=0xFFFFFFFF, B=1 -> result 0, C=1, Z=1, O=0; add A=0x7FFFFFFF, B=1 -> 0x80000000, O=1, N=1.
REQ-034 SHALL pass: mul A=100, B=2 -> out_valid exactly 33 cycles after accept (N=32), result 200; mul A=0x10000, B=0x10000 -> result 0, O=1, Z=1.
REQ-035 SHALL pass: div A=50, B=3 -> result 16 after 33 cycles; div A=7, B=0 -> 0xFFFFFFFF, O=1; out_ready held 0 for 5 cycles -> result stable, in_ready=0.
REQ-036 SHALL pass: rst asserted 10 cycles into div -> next cycle in_ready=1, out_valid=0, result=0; new add 2+3 then returns 5.

Source files
------------

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle add/sub/logic/shift, iterative shift-add multiply
// and restoring divide, with valid/ready handshakes on both sides.
module alu_mc #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [2:0]   opcode,
    input  logic [N-1:0] operandA,
    input  logic [N-1:0] operandB,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] result,
    output logic         C_Flag,
    output logic         O_Flag,
    output logic         N_Flag,
    output logic         Z_Flag
);
    localparam int CW = $clog2(N + 1);
    localparam int SW = $clog2(N);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_MUL = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_OR  = 3'b100;
    localparam logic [2:0] OP_DIV = 3'b101;
    localparam logic [2:0] OP_XOR = 3'b110;
    localparam logic [2:0] OP_SHL = 3'b111;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt;
    logic [2:0]    op_q;
    logic [N-1:0]  a_q, b_q, hi_q, lo_q;

    logic          accept, is_iter, last_iter;
    logic [N:0]    add_sum;
    logic [N-1:0]  sub_diff;
    logic [N-1:0]  sc_res;
    logic          sc_c, sc_o;

    logic [N:0]    mul_sel;
    logic [N:0]    div_shift;
    logic          div_ge;
    logic [N-1:0]  hi_nxt, lo_nxt;
    logic [N-1:0]  it_res;
    logic          it_o;

    logic [N-1:0]  fin_res;
    logic          fin_c, fin_o;

    assign accept    = (state == IDLE) && in_valid;
    assign is_iter   = (opcode == OP_MUL) || (opcode == OP_DIV);
    assign last_iter = (state == BUSY) && (cnt == CW'(1));

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = is_iter ? BUSY : DONE;
            end
            BUSY: begin
                if (cnt == CW'(1)) state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        add_sum  = {1'b0, operandA} + {1'b0, operandB};
        sub_diff = operandA - operandB;
        sc_res   = '0;
        sc_c     = 1'b0;
        sc_o     = 1'b0;
        case (opcode)
            OP_ADD: begin
                sc_res = add_sum[N-1:0];
                sc_c   = add_sum[N];
                sc_o   = (operandA[N-1] == operandB[N-1]) && (add_sum[N-1] != operandA[N-1]);
            end
            OP_SUB: begin
                sc_res = sub_diff;
                sc_c   = (operandA >= operandB);
                sc_o   = (operandA[N-1] != operandB[N-1]) && (sub_diff[N-1] != operandA[N-1]);
            end
            OP_AND:  sc_res = operandA & operandB;
            OP_OR:   sc_res = operandA | operandB;
            OP_XOR:  sc_res = operandA ^ operandB;
            OP_SHL:  sc_res = operandA << operandB[SW-1:0];
            default: sc_res = '0;
        endcase
    end

    // hi/lo hold {partial product, multiplier} for mul, {remainder, dividend/quotient} for div
    always_comb begin
        mul_sel   = lo_q[0] ? ({1'b0, hi_q} + {1'b0, a_q}) : {1'b0, hi_q};
        div_shift = {hi_q, lo_q[N-1]};
        div_ge    = (div_shift >= {1'b0, b_q});
        if (op_q == OP_DIV) begin
            hi_nxt = div_ge ? (div_shift[N-1:0] - b_q) : div_shift[N-1:0];
            lo_nxt = {lo_q[N-2:0], div_ge};
        end else begin
            hi_nxt = mul_sel[N:1];
            lo_nxt = {mul_sel[0], lo_q[N-1:1]};
        end
        if (op_q == OP_DIV) begin
            it_res = (b_q == '0) ? '1 : lo_nxt;
            it_o   = (b_q == '0);
        end else begin
            it_res = lo_nxt;
            it_o   = |hi_nxt;
        end
    end

    always_comb begin
        fin_res = sc_res;
        fin_c   = sc_c;
        fin_o   = sc_o;
        if (state == BUSY) begin
            fin_res = it_res;
            fin_c   = 1'b0;
            fin_o   = it_o;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            op_q   <= '0;
            a_q    <= '0;
            b_q    <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            result <= '0;
            C_Flag <= 1'b0;
            O_Flag <= 1'b0;
            N_Flag <= 1'b0;
            Z_Flag <= 1'b0;
        end else if (accept) begin
            op_q <= opcode;
            a_q  <= operandA;
            b_q  <= operandB;
            if (is_iter) begin
                cnt  <= CW'(N);
                hi_q <= '0;
                lo_q <= (opcode == OP_MUL) ? operandB : operandA;
            end else begin
                result <= fin_res;
                C_Flag <= fin_c;
                O_Flag <= fin_o;
                N_Flag <= fin_res[N-1];
                Z_Flag <= (fin_res == '0);
            end
        end else if (state == BUSY) begin
            hi_q <= hi_nxt;
            lo_q <= lo_nxt;
            cnt  <= cnt - CW'(1);
            if (last_iter) begin
                result <= fin_res;
                C_Flag <= fin_c;
                O_Flag <= fin_o;
                N_Flag <= fin_res[N-1];
                Z_Flag <= (fin_res == '0);
            end
        end
    end
endmodule

// File: tb/tb_alu_mc.sv
// Directed vector bench for alu_mc: latency, result, flags and handshake
// per vector, plus stall and reset-during-divide sequences.
module tb_alu_mc;
    localparam int N = 32;

    logic         clk = 1'b0;
    logic         rst, in_valid, in_ready, out_valid, out_ready;
    logic [2:0]   opcode;
    logic [N-1:0] operandA, operandB, result;
    logic         C_Flag, O_Flag, N_Flag, Z_Flag;

    int n_checks = 0;
    int n_fail   = 0;

    alu_mc #(.N(N)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .operandA(operandA), .operandB(operandB),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result),
        .C_Flag(C_Flag), .O_Flag(O_Flag), .N_Flag(N_Flag), .Z_Flag(Z_Flag)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]   op;
        logic [N-1:0] a, b;
        int           lat;
        logic [N-1:0] res;
        logic [3:0]   flags;   // {C,O,N,Z}
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic issue(input logic [2:0] op, input logic [N-1:0] a, input logic [N-1:0] b);
        in_valid = 1'b1;
        opcode   = op;
        operandA = a;
        operandB = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        opcode   = 3'($urandom);
        operandA = $urandom;
        operandB = $urandom;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 1;
        while (!out_valid && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic handoff();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        chk("handoff_out_valid", 64'(out_valid), 64'(1'b0));
        chk("handoff_in_ready", 64'(in_ready), 64'(1'b1));
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int cyc;
        issue(v.op, v.a, v.b);
        if (v.lat > 1) chk($sformatf("v%0d_busy_in_ready", idx), 64'(in_ready), 64'(1'b0));
        wait_done(cyc);
        chk($sformatf("v%0d_latency", idx), 64'(cyc), 64'(v.lat));
        chk($sformatf("v%0d_result", idx), 64'(result), 64'(v.res));
        chk($sformatf("v%0d_flags_CONZ", idx), 64'({C_Flag, O_Flag, N_Flag, Z_Flag}), 64'(v.flags));
        handoff();
    endtask

    initial begin
        int   cyc;
        logic [N-1:0] held;

        //               op      a             b             lat res           CONZ
        vecs.push_back('{3'b001, 32'd32,       32'd32,       1,  32'h0,        4'b1001});
        vecs.push_back('{3'b001, 32'd32,       32'd64,       1,  32'hFFFFFFE0, 4'b0010});
        vecs.push_back('{3'b000, 32'hFFFFFFFF, 32'd1,        1,  32'h0,        4'b1001});
        vecs.push_back('{3'b000, 32'h7FFFFFFF, 32'd1,        1,  32'h80000000, 4'b0110});
        vecs.push_back('{3'b000, 32'h80000000, 32'h80000000, 1,  32'h0,        4'b1101});
        vecs.push_back('{3'b001, 32'd3,        32'd5,        1,  32'hFFFFFFFE, 4'b0010});
        vecs.push_back('{3'b001, 32'h80000000, 32'd1,        1,  32'h7FFFFFFF, 4'b1100});
        vecs.push_back('{3'b011, 32'hF0F0F0F0, 32'hFF00FF00, 1,  32'hF000F000, 4'b0010});
        vecs.push_back('{3'b100, 32'h0000000F, 32'h000000F0, 1,  32'h000000FF, 4'b0000});
        vecs.push_back('{3'b110, 32'hAAAAAAAA, 32'hAAAAAAAA, 1,  32'h0,        4'b0001});
        vecs.push_back('{3'b111, 32'd1,        32'd35,       1,  32'd8,        4'b0000});
        vecs.push_back('{3'b010, 32'd100,      32'd2,        33, 32'd200,      4'b0000});
        vecs.push_back('{3'b010, 32'h10000,    32'h10000,    33, 32'h0,        4'b0101});
        vecs.push_back('{3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 33, 32'h1,        4'b0100});
        vecs.push_back('{3'b101, 32'd50,       32'd3,        33, 32'd16,       4'b0000});
        vecs.push_back('{3'b101, 32'hFFFFFFFF, 32'd1,        33, 32'hFFFFFFFF, 4'b0010});
        vecs.push_back('{3'b101, 32'd100,      32'd7,        33, 32'd14,       4'b0000});

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        opcode = 3'b000; operandA = '0; operandB = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset_in_ready", 64'(in_ready), 64'(1'b1));
        chk("reset_out_valid", 64'(out_valid), 64'(1'b0));
        chk("reset_result", 64'(result), 64'(0));
        chk("reset_flags", 64'({C_Flag, O_Flag, N_Flag, Z_Flag}), 64'(0));

        foreach (vecs[i]) run_vec(vecs[i], i);

        // divide by zero, then consumer stalls for 5 cycles
        issue(3'b101, 32'd7, 32'd0);
        wait_done(cyc);
        chk("div0_latency", 64'(cyc), 64'(33));
        chk("div0_result", 64'(result), 64'hFFFFFFFF);
        chk("div0_flags_CONZ", 64'({C_Flag, O_Flag, N_Flag, Z_Flag}), 64'(4'b0110));
        held = result;
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1;
            @(posedge clk);
            #1;
            chk($sformatf("stall%0d_result", k), 64'(result), 64'(held));
            chk($sformatf("stall%0d_flags", k), 64'({C_Flag, O_Flag, N_Flag, Z_Flag}), 64'(4'b0110));
            chk($sformatf("stall%0d_in_ready", k), 64'(in_ready), 64'(1'b0));
            chk($sformatf("stall%0d_out_valid", k), 64'(out_valid), 64'(1'b1));
        end
        in_valid = 1'b0;
        handoff();

        // reset 10 cycles into a divide
        issue(3'b101, 32'd50, 32'd3);
        repeat (9) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        chk("midrst_in_ready", 64'(in_ready), 64'(1'b1));
        chk("midrst_out_valid", 64'(out_valid), 64'(1'b0));
        chk("midrst_result", 64'(result), 64'(0));

        // reset wins over a simultaneous request
        rst = 1'b1; in_valid = 1'b1; opcode = 3'b000; operandA = 32'd9; operandB = 32'd9;
        @(posedge clk);
        #1 rst = 1'b0; in_valid = 1'b0;
        chk("rst_prio_in_ready", 64'(in_ready), 64'(1'b1));
        chk("rst_prio_result", 64'(result), 64'(0));

        run_vec('{3'b000, 32'd2, 32'd3, 1, 32'd5, 4'b0000}, 99);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
